spi_cmd_rx: RTL and testbench

//  MCU->FPGA half of the SPI link: oversamples spi_clk/spi_cs/spi_si in the pll_clk domain,

---
 rtl/opentrig_spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_cmd_rx.sv | 158 +++++++++++++++
 tb/tb_spi_cmd_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/opentrig_spi_pkg.sv
// Shared definitions for the opentrig SPI link (command receiver, spi_so
// shifter and trigger core).
//   state_t     : receiver frame state (IDLE, CMD, DATA, DONE)
//   CMD_W       : command byte width; CMD_WR_BIT selects write (1) / read (0)
//   FRAME_BITS  : total frame length for a given data field width
//   REG_*       : register addresses decoded by the trigger core
package opentrig_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;

  localparam logic [6:0] REG_TIMEOUT   = 7'h01;
  localparam logic [6:0] REG_TRIG_MASK = 7'h02;
  localparam logic [6:0] REG_ARM_MASK  = 7'h03;
  localparam logic [6:0] REG_DEBUG_MUX = 7'h05;

  function automatic int FRAME_BITS(input int data_w);
    return CMD_W + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous SPI input.
//   clk    : sampling clock
//   reset  : asynchronous active-low reset, clears every flop
//   din    : asynchronous input
//   level  : synchronized level (last synchronizer stage)
//   rise   : one-cycle pulse on a synchronized 0->1 transition
//   fall   : one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sr[STAGES-1:0] are the synchronizer flops, sr[STAGES] is the history flop
  logic [STAGES:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-1:0], din};
    end
  end

  assign level = sr[STAGES-1];
  assign rise  = sr[STAGES-1] & ~sr[STAGES];
  assign fall  = ~sr[STAGES-1] & sr[STAGES];

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command frame receiver (MCU -> FPGA).
// Frame: command byte (bit 7 = write, bits 6:0 = address) then DATA_W data
// bits, MSB first. Issues one-cycle register write / read strobes.
//   pll_clk   : sole clock (spi_clk must be <= pll_clk/8)
//   reset     : asynchronous active-low reset
//   spi_clk   : SPI clock, idle low, asynchronous
//   spi_cs    : SPI chip select, active low, asynchronous
//   spi_si    : SPI MOSI, sampled on spi_clk rising edge
//   wr_valid  : write strobe; wr_addr / wr_data held until next write
//   rd_req    : read strobe after command byte; rd_addr held until next read
//   frame_err : strobe when cs rises on a partially received frame
//   busy      : high while a frame is in progress (CMD, DATA)
module spi_cmd_rx
  import opentrig_spi_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pll_clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_si,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_BITS(DATA_W) + 1);
  localparam logic [CNT_W-1:0] LAST_CMD_BIT   = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME_BIT = CNT_W'(FRAME_BITS(DATA_W) - 1);

  logic clk_level, clk_rise, clk_fall;
  logic cs_high, cs_rise, cs_fall;
  logic si_level, si_rise, si_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(pll_clk), .reset(reset), .din(spi_clk),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(pll_clk), .reset(reset), .din(spi_cs),
    .level(cs_high), .rise(cs_rise), .fall(cs_fall)
  );

  // MOSI goes through an identical chain so its level lines up with clk_rise
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_si (
    .clk(pll_clk), .reset(reset), .din(spi_si),
    .level(si_level), .rise(si_rise), .fall(si_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, clk_level, clk_fall, cs_rise, si_rise, si_fall};

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CMD_W-2:0]     cmd_sr;
  logic [CMD_W-1:0]     cmd_reg;
  logic [DATA_W-1:0]    data_sr;
  // Strobes are staged one cycle behind the deciding edge so that the
  // registered output lands at SYNC_STAGES+1 cycles and so that an abort
  // straight after the command byte cannot coincide with rd_req.
  logic                 wr_pend, rd_pend, err_pend;

  logic [CMD_W-1:0]     cmd_next;
  logic [DATA_W-1:0]    data_next;

  assign cmd_next  = {cmd_sr, si_level};
  assign data_next = {data_sr[DATA_W-2:0], si_level};

  always_ff @(posedge pll_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      cmd_reg   <= '0;
      data_sr   <= '0;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      err_pend  <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_valid  <= wr_pend;
      rd_req    <= rd_pend;
      frame_err <= err_pend;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      err_pend  <= 1'b0;
      if (wr_pend) begin
        wr_addr <= cmd_reg[ADDR_W-1:0];
        wr_data <= data_sr;
      end
      if (rd_pend) begin
        rd_addr <= cmd_reg[ADDR_W-1:0];
      end

      case (state)
        IDLE: begin
          // only a real high->low transition starts a frame, so cs held low
          // through reset release is ignored until it goes high first
          if (cs_fall) begin
            state   <= CMD;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        CMD, DATA: begin
          // cs_high takes priority over a coincident spi_clk rise
          if (cs_high) begin
            state    <= IDLE;
            busy     <= 1'b0;
            err_pend <= (bit_cnt != '0);
          end else if (clk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (state == CMD) begin
              cmd_sr <= cmd_next[CMD_W-2:0];
              if (bit_cnt == LAST_CMD_BIT) begin
                state   <= DATA;
                cmd_reg <= cmd_next;
                rd_pend <= ~cmd_next[CMD_WR_BIT];
              end
            end else begin
              data_sr <= data_next;
              if (bit_cnt == LAST_FRAME_BIT) begin
                state   <= DONE;
                busy    <= 1'b0;
                wr_pend <= cmd_reg[CMD_WR_BIT];
              end
            end
          end
        end
        DONE: begin
          // surplus bits are dropped; no second frame within one cs window
          if (cs_high) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_rx.sv
`timescale 1ns/1ps
module tb_spi_cmd_rx;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 7;
  localparam int FB     = 8 + DATA_W;

  logic              pll_clk = 1'b0;
  logic              reset   = 1'b0;
  logic              spi_clk = 1'b0;
  logic              spi_cs  = 1'b1;
  logic              spi_si  = 1'b0;
  logic              wr_valid, rd_req, frame_err, busy;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;

  spi_cmd_rx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .pll_clk(pll_clk), .reset(reset),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_si(spi_si),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .frame_err(frame_err), .busy(busy)
  );

  // 40 MHz
  always #12.5 pll_clk = ~pll_clk;

  int          n_vec   = 0;
  int          n_miss  = 0;
  int          cyc     = 0;
  int          n_multi = 0;
  logic        probe_busy = 1'b0;
  int          rise_cyc [40];
  logic [63:0] obs_q [$];
  int          obs_cyc [$];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor: one record per strobe, tagged with the pll_clk edge count.
  always @(posedge pll_clk) begin
    cyc <= cyc + 1;
    #1;
    if ((int'(wr_valid) + int'(rd_req) + int'(frame_err)) > 1) n_multi <= n_multi + 1;
    if (wr_valid) begin
      obs_q.push_back({31'd0, 2'd1, wr_addr, wr_data});
      obs_cyc.push_back(cyc);
    end
    if (rd_req) begin
      obs_q.push_back({31'd0, 2'd2, rd_addr, 24'd0});
      obs_cyc.push_back(cyc);
    end
    if (frame_err) begin
      obs_q.push_back({31'd0, 2'd3, 7'd0, 24'd0});
      obs_cyc.push_back(cyc);
    end
  end

  // Expected strobes of one cs window from the frame rules alone.
  task automatic model(input logic [39:0] f, input int n);
    logic [7:0]  cmd;
    logic [23:0] data;
    cmd  = f[39:32];
    data = f[31:8];
    exp_q.delete();
    if (n >= 8 && !cmd[7]) exp_q.push_back({31'd0, 2'd2, cmd[6:0], 24'd0});
    if (n >= FB && cmd[7]) exp_q.push_back({31'd0, 2'd1, cmd[6:0], data});
    if (n > 0 && n < FB)   exp_q.push_back({31'd0, 2'd3, 7'd0, 24'd0});
  endtask

  task automatic compare_events(input string tag);
    int m;
    check({tag, "_nev"}, 64'(obs_q.size()), 64'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  // Shift bits first..last of f (MSB first); 100 ns half period = pll_clk/8.
  task automatic send_bits(input logic [39:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      spi_si = f[39-i];
      #100;
      spi_clk = 1'b1;
      rise_cyc[i] = cyc;
      if (probe_busy && i == 3) begin
        #30;
        check("busy_mid", 64'(busy), 64'd1);
        #70;
      end else begin
        #100;
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [39:0] f, input int n, input logic align);
    obs_q.delete();
    obs_cyc.delete();
    if (align) @(negedge pll_clk);
    else #(real'($urandom_range(0, 24999)) / 1000.0);
    spi_cs = 1'b0;
    #100;
    if (n > 0) send_bits(f, 0, n - 1);
    #100;
    spi_cs = 1'b1;
    #400;
    model(f, n);
    compare_events(tag);
  endtask

  initial begin
    logic [39:0] f;
    int          n;
    int          lat;
    int          r;

    #1;
    check("reset_out", 64'({wr_valid, rd_req, frame_err, busy, wr_addr, wr_data, rd_addr}), 64'd0);
    #60;
    reset = 1'b1;
    #200;

    // 1: write 0x85 / 0x000018, latency from last spi_clk rise, busy
    probe_busy = 1'b1;
    run_frame("t1_wr", {8'h85, 24'h000018, 8'h00}, FB, 1'b1);
    probe_busy = 1'b0;
    lat = (obs_cyc.size() > 0) ? obs_cyc[0] - rise_cyc[FB-1] - 1 : -1;
    check("t1_wr_lat", 64'(lat), 64'd3);
    check("t1_wr_addr", 64'(wr_addr), 64'h05);
    check("t1_wr_data", 64'(wr_data), 64'h000018);
    check("t1_busy_end", 64'(busy), 64'd0);

    // 2: read 0x05 with dummy data
    run_frame("t2_rd", {8'h05, 24'(($urandom)), 8'h00}, FB, 1'b1);
    lat = (obs_cyc.size() > 0) ? obs_cyc[0] - rise_cyc[7] - 1 : -1;
    check("t2_rd_lat", 64'(lat), 64'd3);
    check("t2_rd_addr", 64'(rd_addr), 64'h05);
    check("t2_wr_held", 64'(wr_data), 64'h000018);

    // 3: abort after 13 bits, then a clean frame
    run_frame("t3_abort", {8'h85, 24'hFFFFFF, 8'h00}, 13, 1'b0);
    check("t3_wr_held", 64'(wr_data), 64'h000018);
    run_frame("t3_after", {8'h9A, 24'h5A5A5A, 8'h00}, FB, 1'b0);

    // 4: 40 bits in one cs window, surplus ignored
    run_frame("t4_long", {8'h81, 24'hABCDEF, 8'h5A}, 40, 1'b0);
    check("t4_wr_data", 64'(wr_data), 64'hABCDEF);

    // 5: reset at bit 20 with cs low, released with cs still low
    obs_q.delete();
    obs_cyc.delete();
    f = {8'h83, 24'h123456, 8'h00};
    spi_cs = 1'b0;
    #100;
    send_bits(f, 0, 19);
    #30;
    reset = 1'b0;
    #1;
    check("t5_rst_out", 64'({wr_valid, rd_req, frame_err, busy, wr_addr, wr_data, rd_addr}), 64'd0);
    #60;
    reset = 1'b1;
    #100;
    send_bits(f, 20, FB - 1);
    #200;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_no_ev", 64'(obs_q.size()), 64'd0);
    spi_cs = 1'b1;
    #400;
    check("t5_no_ev_cs", 64'(obs_q.size()), 64'd0);
    run_frame("t5_after", {8'h87, 24'hC0FFEE, 8'h00}, FB, 1'b0);

    // 6: random frames with random async phase
    for (int k = 0; k < 180; k++) begin
      f = {8'($urandom), 24'($urandom), 8'($urandom)};
      r = $urandom_range(0, 9);
      if (r < 7)       n = FB;
      else if (r == 7) n = $urandom_range(0, FB - 1);
      else if (r == 8) n = 40;
      else             n = $urandom_range(0, 12);
      run_frame($sformatf("t6_%0d", k), f, n, 1'b0);
    end

    check("multi_strobe", 64'(n_multi), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
